// File: rtl/if_prefetch_queue_if.sv
// rtl/if_prefetch_queue_if.sv - fetch-side bundle: imem handshake, redirect/hold controls, IF/ID head outputs
interface if_prefetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        hold;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc_plus_four;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc_plus_four,
    input  imem_ack, imem_rdata, redirect, redirect_pc, hold
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc_plus_four,
    output imem_ack, imem_rdata, redirect, redirect_pc, hold
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - instruction prefetch: owns fetch PC, one outstanding imem request,
// buffers {word, pc+4} in a DEPTH-entry FIFO feeding IF/ID, flushes on branch redirect.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  if_prefetch_queue_if.master   bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DROP} state_t;

  state_t        r_state;
  logic          r_req;
  logic [31:0]   r_addr;
  logic [31:0]   r_fetch_pc;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_inst_mem [DEPTH];
  logic [31:0]   r_pc4_mem  [DEPTH];

  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_count_next;
  logic          w_room;

  assign w_valid      = (r_count != '0);
  assign w_pop        = w_valid & ~bus.hold & ~bus.redirect;
  assign w_push       = (r_state == S_BUSY) & bus.imem_ack & ~bus.redirect;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  assign w_room       = (w_count_next < CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst_mem[r_wr_ptr] <= bus.imem_rdata;
      r_pc4_mem[r_wr_ptr]  <= r_addr + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (bus.redirect) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        r_count <= w_count_next;
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.redirect) begin
            r_state    <= S_BUSY;
            r_req      <= 1'b1;
            r_addr     <= bus.redirect_pc;
            r_fetch_pc <= bus.redirect_pc + 32'd4;
          end else if (w_room) begin
            r_state    <= S_BUSY;
            r_req      <= 1'b1;
            r_addr     <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + 32'd4;
          end
        end
        S_BUSY: begin
          if (bus.imem_ack && bus.redirect) begin
            r_addr     <= bus.redirect_pc;
            r_fetch_pc <= bus.redirect_pc + 32'd4;
          end else if (bus.redirect) begin
            // Request still in flight: keep its address until the stale ack retires it.
            r_state    <= S_DROP;
            r_fetch_pc <= bus.redirect_pc;
          end else if (bus.imem_ack) begin
            if (w_room) begin
              r_addr     <= r_fetch_pc;
              r_fetch_pc <= r_fetch_pc + 32'd4;
            end else begin
              r_state <= S_IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        S_DROP: begin
          if (bus.imem_ack) begin
            r_state <= S_BUSY;
            if (bus.redirect) begin
              r_addr     <= bus.redirect_pc;
              r_fetch_pc <= bus.redirect_pc + 32'd4;
            end else begin
              r_addr     <= r_fetch_pc;
              r_fetch_pc <= r_fetch_pc + 32'd4;
            end
          end else if (bus.redirect) begin
            r_fetch_pc <= bus.redirect_pc;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req          = r_req;
  assign bus.imem_addr         = r_addr;
  assign bus.inst_valid        = w_valid;
  assign bus.inst              = w_valid ? r_inst_mem[r_rd_ptr] : 32'h0;
  assign bus.inst_pc_plus_four = w_valid ? r_pc4_mem[r_rd_ptr]  : 32'h0;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb/tb_if_prefetch_queue.sv - directed vector table plus hand sequences for redirect, reset and PC wrap
module tb_if_prefetch_queue;

  typedef struct {
    logic        hold;
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc4;
    logic        exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        use_auto = 1'b1;
  int          lat = 0;
  int          wait_cnt = 0;
  logic        a_ack = 1'b1;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  int          n_total = 0;
  int          n_bad = 0;

  if_prefetch_queue_if bus1();
  if_prefetch_queue_if bus2();

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));
  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  // Memory content model: word at address A is (A >> 2) + 1.
  assign bus1.imem_ack   = use_auto ? a_ack : m_ack;
  assign bus1.imem_rdata = use_auto ? ((bus1.imem_addr >> 2) + 32'd1) : m_rdata;
  assign bus2.imem_ack   = 1'b1;
  assign bus2.imem_rdata = (bus2.imem_addr >> 2) + 32'd1;
  assign bus2.redirect    = 1'b0;
  assign bus2.redirect_pc = 32'h0;
  assign bus2.hold        = 1'b0;

  always @(negedge clk) begin
    if (lat == 0) begin
      a_ack = 1'b1;
    end else if (rst || !bus1.imem_req) begin
      a_ack = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= lat - 1) begin
      a_ack = 1'b1;
      wait_cnt = 0;
    end else begin
      a_ack = 1'b0;
      wait_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  vec_t vecs [21];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'd0,  32'd0,  1'b1, 32'd0};
    vecs[1]  = '{1'b0, 1'b1, 32'd1,  32'd4,  1'b1, 32'd4};
    vecs[2]  = '{1'b0, 1'b1, 32'd2,  32'd8,  1'b1, 32'd8};
    vecs[3]  = '{1'b0, 1'b1, 32'd3,  32'd12, 1'b1, 32'd12};
    vecs[4]  = '{1'b0, 1'b1, 32'd4,  32'd16, 1'b1, 32'd16};
    vecs[5]  = '{1'b0, 1'b1, 32'd5,  32'd20, 1'b1, 32'd20};
    vecs[6]  = '{1'b1, 1'b1, 32'd5,  32'd20, 1'b1, 32'd24};
    vecs[7]  = '{1'b1, 1'b1, 32'd5,  32'd20, 1'b1, 32'd28};
    for (int k = 8; k < 16; k++) vecs[k] = '{1'b1, 1'b1, 32'd5, 32'd20, 1'b0, 32'd28};
    vecs[16] = '{1'b0, 1'b1, 32'd6,  32'd24, 1'b1, 32'd32};
    vecs[17] = '{1'b0, 1'b1, 32'd7,  32'd28, 1'b1, 32'd36};
    vecs[18] = '{1'b0, 1'b1, 32'd8,  32'd32, 1'b1, 32'd40};
    vecs[19] = '{1'b0, 1'b1, 32'd9,  32'd36, 1'b1, 32'd44};
    vecs[20] = '{1'b0, 1'b1, 32'd10, 32'd40, 1'b1, 32'd48};

    bus1.hold = 1'b0;
    bus1.redirect = 1'b0;
    bus1.redirect_pc = 32'h0;

    #2 rst = 1'b1;
    #1;
    chk("rst_req",   32'(bus1.imem_req), 32'd0);
    chk("rst_addr",  bus1.imem_addr, 32'h0);
    chk("rst_valid", 32'(bus1.inst_valid), 32'd0);
    chk("rst_inst",  bus1.inst, 32'h0);
    chk("rst_pc4",   bus1.inst_pc_plus_four, 32'h0);
    chk("rst_addr2", bus2.imem_addr, 32'hFFFF_FFF8);
    step();
    step();
    rst = 1'b0;
    chk("rel_req", 32'(bus1.imem_req), 32'd0);

    // Streaming with zero-wait memory, then hold-fill and release.
    for (int i = 0; i < 21; i++) begin
      bus1.hold = vecs[i].hold;
      step();
      chk($sformatf("v%0d_valid", i), 32'(bus1.inst_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_inst", i), bus1.inst, vecs[i].exp_inst);
      chk($sformatf("v%0d_pc4", i), bus1.inst_pc_plus_four, vecs[i].exp_pc4);
      chk($sformatf("v%0d_req", i), 32'(bus1.imem_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req) chk($sformatf("v%0d_addr", i), bus1.imem_addr, vecs[i].exp_addr);
      if (i == 0) chk("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFF8);
      if (i == 1) begin
        chk("wrap_addr1", bus2.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc4_1", bus2.inst_pc_plus_four, 32'hFFFF_FFFC);
      end
      if (i == 2) begin
        chk("wrap_addr2", bus2.imem_addr, 32'h0000_0000);
        chk("wrap_pc4_2", bus2.inst_pc_plus_four, 32'h0000_0000);
      end
      if (i == 3) chk("wrap_pc4_3", bus2.inst_pc_plus_four, 32'h0000_0004);
    end

    // Redirect while a 3-cycle fetch is in flight.
    bus1.hold = 1'b1;
    lat = 3;
    pulse_reset();
    step(); step(); step(); step();
    chk("t3_pre_valid", 32'(bus1.inst_valid), 32'd1);
    chk("t3_pre_inst", bus1.inst, 32'd1);
    bus1.redirect = 1'b1;
    bus1.redirect_pc = 32'h40;
    step();
    bus1.redirect = 1'b0;
    bus1.hold = 1'b0;
    chk("t3_flush_valid", 32'(bus1.inst_valid), 32'd0);
    chk("t3_stale_addr", bus1.imem_addr, 32'h4);
    step();
    chk("t3_drop_valid", 32'(bus1.inst_valid), 32'd0);
    step();
    chk("t3_new_addr", bus1.imem_addr, 32'h40);
    chk("t3_new_req", 32'(bus1.imem_req), 32'd1);
    chk("t3_stale_gone", 32'(bus1.inst_valid), 32'd0);
    step();
    step();
    chk("t3_wait_valid", 32'(bus1.inst_valid), 32'd0);
    step();
    chk("t3_tgt_valid", 32'(bus1.inst_valid), 32'd1);
    chk("t3_tgt_inst", bus1.inst, 32'd17);
    chk("t3_tgt_pc4", bus1.inst_pc_plus_four, 32'h44);

    // Redirect coinciding with an ack.
    lat = 0;
    pulse_reset();
    step();
    chk("t4_addr0", bus1.imem_addr, 32'h0);
    bus1.redirect = 1'b1;
    bus1.redirect_pc = 32'h80;
    step();
    bus1.redirect = 1'b0;
    chk("t4_addr", bus1.imem_addr, 32'h80);
    chk("t4_valid", 32'(bus1.inst_valid), 32'd0);
    step();
    chk("t4_inst", bus1.inst, 32'd33);
    chk("t4_pc4", bus1.inst_pc_plus_four, 32'h84);

    // Reset mid-BUSY followed by a late ack.
    use_auto = 1'b0;
    bus1.hold = 1'b1;
    m_ack = 1'b0;
    pulse_reset();
    step();
    m_ack = 1'b1;
    m_rdata = 32'h1234;
    step();
    m_ack = 1'b0;
    chk("t5_pre_inst", bus1.inst, 32'h1234);
    chk("t5_pre_addr", bus1.imem_addr, 32'h4);
    step();
    rst = 1'b1;
    #1;
    chk("t5_rst_req", 32'(bus1.imem_req), 32'd0);
    chk("t5_rst_addr", bus1.imem_addr, 32'h0);
    chk("t5_rst_valid", 32'(bus1.inst_valid), 32'd0);
    chk("t5_rst_inst", bus1.inst, 32'h0);
    chk("t5_rst_pc4", bus1.inst_pc_plus_four, 32'h0);
    m_ack = 1'b1;
    m_rdata = 32'hDEAD;
    step();
    rst = 1'b0;
    step();
    m_ack = 1'b0;
    chk("t5_late_valid", 32'(bus1.inst_valid), 32'd0);
    chk("t5_restart_req", 32'(bus1.imem_req), 32'd1);
    chk("t5_restart_addr", bus1.imem_addr, 32'h0);
    step();
    chk("t5_still_empty", 32'(bus1.inst_valid), 32'd0);
    m_ack = 1'b1;
    m_rdata = 32'h55;
    step();
    m_ack = 1'b0;
    chk("t5_first_inst", bus1.inst, 32'h55);
    chk("t5_first_pc4", bus1.inst_pc_plus_four, 32'h4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
